// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - two-source write-back stage driving the register file write port
//
// Results from the ALU and the load unit arrive over valid/ready handshakes,
// are filtered (r0 and out-of-range addresses discarded), buffered in one
// FIFO per source, and drained one per cycle with round-robin arbitration
// into registered wr_* outputs. A per-register occupancy counter yields the
// pending-write mask used by issue to stall on outstanding writes.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/ready/addr/data     ALU result handshake (6-bit addr)
//   mem_valid/ready/addr/data     load-unit result handshake (6-bit addr)
//   wr_enable/wr_addr/wr_data     registered register-file write port
//   pending[31:0]                 write to register i queued or in flight
//   addr_err                      sticky: accepted beat with addr >= 32
module regfile_writeback #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [5:0]        alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [5:0]        mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wr_enable,
    output logic [5:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [31:0]       pending,
    output logic              addr_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    // Entry is {5-bit register index, data}; only in-range addresses are stored.
    localparam int EW = 5 + DATA_W;
    // Counter must hold up to 2*FIFO_DEPTH+1 (both FIFOs plus the output stage).
    localparam int CW = $clog2(2 * FIFO_DEPTH + 2);
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t          last_grant;

    logic [EW-1:0]   fifo_mem   [2][FIFO_DEPTH];
    logic [PW-1:0]   wptr       [2];
    logic [PW-1:0]   rptr       [2];
    logic [PW:0]     count      [2];
    logic            push       [2];
    logic            pop        [2];
    logic            full       [2];
    logic            empty      [2];
    logic [EW-1:0]   push_entry [2];
    logic [EW-1:0]   head       [2];

    logic            alu_take;
    logic            mem_take;

    logic [CW-1:0]   cnt        [32];
    logic [CW-1:0]   cnt_next   [32];

    // Ready depends only on occupancy and reset, never on valid.
    assign alu_ready = !full[SRC_ALU] && !rst;
    assign mem_ready = !full[SRC_MEM] && !rst;
    assign alu_take  = alu_valid && alu_ready;
    assign mem_take  = mem_valid && mem_ready;

    always_comb begin
        push[SRC_ALU]       = alu_take && !alu_addr[5] && (alu_addr[4:0] != 5'd0);
        push[SRC_MEM]       = mem_take && !mem_addr[5] && (mem_addr[4:0] != 5'd0);
        push_entry[SRC_ALU] = {alu_addr[4:0], alu_data};
        push_entry[SRC_MEM] = {mem_addr[4:0], mem_data};
        for (int s = 0; s < 2; s++) begin
            full[s]  = (count[s] == (PW + 1)'(FIFO_DEPTH));
            empty[s] = (count[s] == '0);
            head[s]  = fifo_mem[s][rptr[s]];
        end
    end

    // Round-robin: under contention the source not granted last time wins.
    always_comb begin
        pop[SRC_ALU] = 1'b0;
        pop[SRC_MEM] = 1'b0;
        if (!empty[SRC_ALU] && !empty[SRC_MEM]) begin
            if (last_grant == GRANT_ALU) begin
                pop[SRC_MEM] = 1'b1;
            end else begin
                pop[SRC_ALU] = 1'b1;
            end
        end else if (!empty[SRC_ALU]) begin
            pop[SRC_ALU] = 1'b1;
        end else if (!empty[SRC_MEM]) begin
            pop[SRC_MEM] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                wptr[s]  <= '0;
                rptr[s]  <= '0;
                count[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    wptr[s] <= wptr[s] + PW'(1);
                end
                if (pop[s]) begin
                    rptr[s] <= rptr[s] + PW'(1);
                end
                if (push[s] && !pop[s]) begin
                    count[s] <= count[s] + (PW + 1)'(1);
                end else if (!push[s] && pop[s]) begin
                    count[s] <= count[s] - (PW + 1)'(1);
                end
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                fifo_mem[s][wptr[s]] <= push_entry[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_enable  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            last_grant <= GRANT_ALU;
            addr_err   <= 1'b0;
        end else begin
            wr_enable <= pop[SRC_ALU] || pop[SRC_MEM];
            if (pop[SRC_ALU]) begin
                wr_addr    <= {1'b0, head[SRC_ALU][EW-1 -: 5]};
                wr_data    <= head[SRC_ALU][DATA_W-1:0];
                last_grant <= GRANT_ALU;
            end else if (pop[SRC_MEM]) begin
                wr_addr    <= {1'b0, head[SRC_MEM][EW-1 -: 5]};
                wr_data    <= head[SRC_MEM][DATA_W-1:0];
                last_grant <= GRANT_MEM;
            end
            if ((alu_take && alu_addr[5]) || (mem_take && mem_addr[5])) begin
                addr_err <= 1'b1;
            end
        end
    end

    // Both sources may enqueue the same register on one edge, so a counter
    // can step by +2; the commit of the registered write is the only decrement.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_next[i] = cnt[i];
            if (push[SRC_ALU] && (alu_addr[4:0] == 5'(i))) begin
                cnt_next[i] = cnt_next[i] + CW'(1);
            end
            if (push[SRC_MEM] && (mem_addr[4:0] == 5'(i))) begin
                cnt_next[i] = cnt_next[i] + CW'(1);
            end
            if (wr_enable && (wr_addr[4:0] == 5'(i))) begin
                cnt_next[i] = cnt_next[i] - CW'(1);
            end
            pending[i] = (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule
